// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall/scheduling controller for the 5-stage MIPS pipeline.
//   It merges the ID load-use stall request with the multi-cycle divider
//   sequencing in EX. It drives the shared StallBus and owns the divider
//   start/ready handshake, which div and divu share.
//
//   Optional build macro: PIPE_STALL_PERF_EN adds three 32-bit performance
//   counters as extra output ports.
//
// Parameters:
//   DIV_CYCLES  cycles the pipeline is frozen per divide, including the
//               start cycle (2..64)
//   CNT_W       divide counter width; 2^CNT_W > DIV_CYCLES-2
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   id_stallreq     ID load-use hazard (level, same cycle)
//   ex_div_req      EX holds a div/divu (held while it sits in EX)
//   div_start       one-cycle pulse that loads the divider operands
//   div_ready       one-cycle pulse; divider result valid, EX may advance
//   div_busy        high while the divider is iterating
//   stall[5:0]      StallBus: [0] PC [1] IF/ID [2] ID/EX [3] EX/MEM
//                   [4] MEM/WB [5] WB; 1 = stop
//   perf_stall_cnt  (PIPE_STALL_PERF_EN) cycles with stall[0]=1
//   perf_luse_cnt   (PIPE_STALL_PERF_EN) cycles with a load-use stall
//   perf_div_cnt    (PIPE_STALL_PERF_EN) number of div_start pulses
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int DIV_CYCLES = 33,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stallreq,
   input  logic        ex_div_req,
   output logic        div_start,
   output logic        div_ready,
   output logic        div_busy,
`ifdef PIPE_STALL_PERF_EN
   output logic [5:0]  stall,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_luse_cnt,
   output logic [31:0] perf_div_cnt
`else
   output logic [5:0]  stall
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The divide freeze holds PC through EX/MEM. The load-use stall holds
   // only PC and IF/ID, so ID/EX takes a bubble.
   localparam logic [5:0] STALL_DIV  = 6'b001111;
   localparam logic [5:0] STALL_LUSE = 6'b000011;
   localparam logic [5:0] STALL_NONE = 6'b000000;

   // BUSY lasts DIV_CYCLES-1 cycles. The counter counts down to zero from
   // DIV_CYCLES-2.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      div_start = 1'b0;
      div_ready = 1'b0;
      div_busy  = 1'b0;
      stall     = STALL_NONE;
      case (state)
         ST_IDLE: begin
            // A divide beats a load-use stall. A bubble must not be
            // inserted behind a frozen EX.
            if (ex_div_req) begin
               div_start = 1'b1;
               stall     = STALL_DIV;
               cnt_nxt   = CNT_LOAD;
               state_nxt = ST_BUSY;
            end else if (id_stallreq) begin
               stall = STALL_LUSE;
            end
         end
         ST_BUSY: begin
            // id_stallreq is ignored. ex_div_req dropping here does not
            // abort the sequence.
            div_busy = 1'b1;
            stall    = STALL_DIV;
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // The divide is still in EX this cycle, so ex_div_req is
            // still high. It is ignored so that the divider does not
            // restart.
            div_ready = 1'b1;
            state_nxt = ST_IDLE;
            if (id_stallreq) begin
               stall = STALL_LUSE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef PIPE_STALL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_luse_cnt  <= '0;
         perf_div_cnt   <= '0;
      end else begin
         if (stall[0]) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (stall == STALL_LUSE) begin
            perf_luse_cnt <= perf_luse_cnt + 32'd1;
         end
         if (div_start) begin
            perf_div_cnt <= perf_div_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Self-checking bench for pipe_stall_ctrl. It uses two instances:
//     dut  : DIV_CYCLES=33 (default)
//     dut4 : DIV_CYCLES=4, used for the back-to-back divide test
//   Each test cycle pushes the expected {div_start, div_ready, div_busy,
//   stall} value onto a scoreboard queue. The value is popped and compared
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_stallreq = 1'b0;
   logic       ex_div_req = 1'b0;
   logic       div_start, div_ready, div_busy;
   logic [5:0] stall;

   logic       id4 = 1'b0;
   logic       ex4 = 1'b0;
   logic       start4, ready4, busy4;
   logic [5:0] stall4;

   logic [8:0] sb[$];
   logic [8:0] got, want;
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .id_stallreq(id_stallreq), .ex_div_req(ex_div_req),
      .div_start(div_start), .div_ready(div_ready), .div_busy(div_busy),
      .stall(stall)
   );

   pipe_stall_ctrl #(.DIV_CYCLES(4), .CNT_W(6)) dut4 (
      .clk(clk), .rst(rst), .id_stallreq(id4), .ex_div_req(ex4),
      .div_start(start4), .div_ready(ready4), .div_busy(busy4),
      .stall(stall4)
   );

   // Expected value for cycle k of a 33-cycle divide. lu is the level
   // of id_stallreq in the DONE cycle.
   function automatic logic [8:0] div33(input int k, input bit lu);
      logic s, r, b;
      logic [5:0] st;
      s  = (k == 0);
      r  = (k == 33);
      b  = (k >= 1 && k <= 32);
      st = (k <= 32) ? 6'b001111 : (lu ? 6'b000011 : 6'b000000);
      return {s, r, b, st};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; id_stallreq = 1'b0; ex_div_req = 1'b0; id4 = 1'b0; ex4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(9'b0_0_0_000000);
         @(negedge clk);
         got = {div_start, div_ready, div_busy, stall};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL reset cyc%0d got=%b want=%b", k, got, want);
         else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_load_use();
      for (int k = 0; k < 3; k++) begin
         id_stallreq = (k == 0);
         sb.push_back((k == 0) ? 9'b0_0_0_000011 : 9'b0_0_0_000000);
         @(negedge clk);
         got = {div_start, div_ready, div_busy, stall};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL load_use cyc%0d got=%b want=%b", k, got, want);
         else n_pass++;
         next_cycle();
      end
      id_stallreq = 1'b0;
   endtask

   // Divide on dut. With lu set, id_stallreq is held high together with
   // ex_div_req. Cycle 34 has both requests low and must show nothing.
   task automatic test_divide(input bit lu, input string nm);
      for (int k = 0; k <= 35; k++) begin
         ex_div_req  = (k <= 33);
         id_stallreq = lu && (k <= 33);
         sb.push_back((k <= 33) ? div33(k, lu) : 9'b0_0_0_000000);
         @(negedge clk);
         got = {div_start, div_ready, div_busy, stall};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL %s cyc%0d got=%b want=%b", nm, k, got, want);
         else n_pass++;
         next_cycle();
      end
      ex_div_req = 1'b0; id_stallreq = 1'b0;
   endtask

   task automatic test_reset_mid_divide();
      for (int k = 0; k <= 10; k++) begin
         ex_div_req = 1'b1;
         rst = (k == 10);
         sb.push_back(div33(k, 1'b0));
         @(negedge clk);
         got = {div_start, div_ready, div_busy, stall};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL rst_mid cyc%0d got=%b want=%b", k, got, want);
         else n_pass++;
         next_cycle();
      end
      rst = 1'b0; ex_div_req = 1'b0;
      // After reset the controller must be idle and must not raise
      // div_ready for the aborted divide.
      for (int k = 0; k < 4; k++) begin
         sb.push_back(9'b0_0_0_000000);
         @(negedge clk);
         got = {div_start, div_ready, div_busy, stall};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL rst_mid_idle cyc%0d got=%b want=%b", k, got, want);
         else n_pass++;
         next_cycle();
      end
      test_divide(1'b0, "div_after_rst");
   endtask

   task automatic test_back_to_back();
      logic s, r, b;
      logic [5:0] st;
      for (int k = 0; k <= 11; k++) begin
         ex4 = (k <= 9);
         s  = (k == 0 || k == 5);
         r  = (k == 4 || k == 9);
         b  = (k >= 1 && k <= 3) || (k >= 6 && k <= 8);
         st = (k <= 8 && k != 4) ? 6'b001111 : 6'b000000;
         sb.push_back({s, r, b, st});
         @(negedge clk);
         got = {start4, ready4, busy4, stall4};
         want = sb.pop_front();
         n_checks++;
         if (got !== want) $display("FAIL back_to_back cyc%0d got=%b want=%b", k, got, want);
         else n_pass++;
         next_cycle();
      end
      ex4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_divide(1'b0, "single_div");
      test_divide(1'b1, "priority");
      test_reset_mid_divide();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
